// File: rtl/number_rom_pkg.sv
// Shared sprite-ROM constants and payload types for the number ROM arbiter.
package number_rom_pkg;

   localparam int unsigned SPRITE_W     = 60;
   localparam int unsigned SPRITE_H     = 150;
   localparam int unsigned SPRITE_WORDS = SPRITE_W * SPRITE_H;
   localparam int unsigned NUM_SPRITES  = 4;

   typedef logic [1:0] sprite_sel_t;
   typedef logic [3:0] pixel_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
// Optional burst hold is built only when NUMBER_ROM_ARB_BURST_EN is defined.
module rr_arb2 #(
   parameter int unsigned BURST_MAX = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   // A zero burst limit has no meaningful interpretation in either mode.
   if (BURST_MAX < 1) begin : g_bad_burst_max
      $error("rr_arb2: BURST_MAX must be at least 1");
   end

   logic last_gnt;   // 1: requester 1 was granted most recently
   logic pick1;
   logic keep;

`ifdef NUMBER_ROM_ARB_BURST_EN
   localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
   logic [CNT_W-1:0] cnt;

   // Current owner keeps the grant until it has used BURST_MAX beats in a row.
   always_comb begin
      keep = 1'b0;
      if ((cnt != '0) && (cnt < CNT_W'(BURST_MAX))) keep = 1'b1;
   end

   // Consecutive-beat counter: restarts on a switch, clears on an idle cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (gnt0 || gnt1) begin
         if ((gnt1 == last_gnt) && (cnt != '0)) begin
            if (cnt != CNT_W'(BURST_MAX)) cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= CNT_W'(1);
         end
      end else begin
         cnt <= '0;
      end
   end
`else
   // Pure alternation: nobody holds the grant through contention.
   always_comb begin
      keep = 1'b0;
   end
`endif

   // Grant decision; both grants are held low while reset is asserted.
   always_comb begin
      pick1 = 1'b0;
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      if (rst_n) begin
         if (req0 && req1) pick1 = keep ? last_gnt : ~last_gnt;
         else              pick1 = req1;
         gnt0 = req0 && !pick1;
         gnt1 = req1 && pick1;
      end
   end

   // Remember the most recent winner; idle cycles leave it untouched.
   always_ff @(posedge clk) begin
      if (!rst_n)            last_gnt <= 1'b1;
      else if (gnt0 || gnt1) last_gnt <= gnt1;
   end

endmodule

// File: rtl/number_rom_arb.sv
// Shares one sprite ROM (1-cycle registered read) between two requesters.
// Optional burst arbitration: define NUMBER_ROM_ARB_BURST_EN.
module number_rom_arb
   import number_rom_pkg::*;
#(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned ADDR_LAST = 8999,
   parameter int unsigned BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  sprite_sel_t       sel0,
   input  sprite_sel_t       sel1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output pixel_t            rdata0,
   output pixel_t            rdata1,
   output sprite_sel_t       rom_sel,
   output logic [ADDR_W-1:0] rom_addr,
   input  pixel_t            rom_data
);

   logic oob;     // granted address lies beyond the last sprite word
   logic oob_q;

   rr_arb2 #(
      .BURST_MAX (BURST_MAX)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   // Steer the winner onto the ROM; out-of-range addresses read word 0.
   always_comb begin
      rom_sel  = '0;
      rom_addr = '0;
      oob      = 1'b0;
      if (gnt0) begin
         rom_sel = sel0;
         if (addr0 > ADDR_W'(ADDR_LAST)) oob = 1'b1;
         else                            rom_addr = addr0;
      end else if (gnt1) begin
         rom_sel = sel1;
         if (addr1 > ADDR_W'(ADDR_LAST)) oob = 1'b1;
         else                             rom_addr = addr1;
      end
   end

   // Response tracking aligned with the ROM's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         rvalid0 <= gnt0;
         rvalid1 <= gnt1;
         oob_q   <= oob;
      end
   end

   // ROM data goes to the valid requester; out-of-range reads return zero.
   assign rdata0 = (rvalid0 && !oob_q) ? rom_data : pixel_t'(0);
   assign rdata1 = (rvalid1 && !oob_q) ? rom_data : pixel_t'(0);

endmodule
